// File: rtl/snn_readout_pkg.sv
// Shared types and helpers for the spike readout accumulator.
//   state_t     : result FSM states (IDLE, CMP, HOLD)
//   NUM_OUT_DEF : default number of output neurons
//   CNT_W_DEF   : default per-neuron counter width
//   sat_inc     : increment-with-saturation on a zero-extended counter value
package snn_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int NUM_OUT_DEF = 2;
  localparam int CNT_W_DEF   = 6;

  // Operates on 32-bit containers so one function serves any counter width;
  // the caller zero-extends and truncates back to its own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val,
                                          input logic        inc);
    if (inc && (val != max_val)) return val + 32'd1;
    return val;
  endfunction

endpackage

// File: rtl/spike_edge_detect.sv
// Rising-edge detector for the SNN step clock.
//   clk       : system clock
//   reset     : synchronous active-high reset
//   delay_clk : step clock, generated in the clk domain (no synchronizer needed)
//   qual      : step qualifier (enable and a non-zero window length)
//   step      : one-cycle pulse on each qualified delay_clk rising edge
module spike_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic delay_clk,
  input  logic qual,
  output logic step
);

  logic delay_clk_q;

  always_ff @(posedge clk) begin
    if (reset) delay_clk_q <= 1'b0;
    else       delay_clk_q <= delay_clk;
  end

  assign step = delay_clk & ~delay_clk_q & qual;

endmodule

// File: rtl/spike_readout_accumulator.sv
// Per-neuron spike counting over a window of SNN steps, followed by a
// sequential argmax and a valid/ack result handshake.
//   clk, reset      : system clock, synchronous active-high reset
//   enable          : SNN enable; low aborts the current window
//   delay_clk       : SNN step clock (clk domain)
//   output_spikes   : spike vector from the output layer
//   window_len      : steps per window, 0 = idle
//   result_ack      : consumer acknowledge (only honoured while result_valid)
//   result_valid    : result pending
//   winner, tie     : argmax index, and shared-max / all-zero flag
//   spike_counts    : snapshot counts, neuron i at [i*CNT_W +: CNT_W]
//   overrun         : sticky, a window ended while a result was still pending
//   spike_history   : last 4 step vectors, newest in the low bits
//                     (only with SPIKE_READOUT_HISTORY_EN defined)
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | waiting for a window-end snapshot
// ST_CMP  | sequential argmax, one neuron per cycle
// ST_HOLD | result presented, result_valid = 1
module spike_readout_accumulator
  import snn_readout_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int WIN_W   = 8,
  parameter int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     delay_clk,
  input  logic [NUM_OUT-1:0]       output_spikes,
  input  logic [WIN_W-1:0]         window_len,
  input  logic                     result_ack,
  output logic                     result_valid,
  output logic [IDX_W-1:0]         winner,
  output logic                     tie,
  output logic [NUM_OUT*CNT_W-1:0] spike_counts,
`ifdef SPIKE_READOUT_HISTORY_EN
  output logic [4*NUM_OUT-1:0]     spike_history,
`endif
  output logic                     overrun
);

  localparam int          IW1     = IDX_W + 1;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic               step;
  logic               win_active;
  logic               win_end;
  logic [WIN_W-1:0]   step_cnt;
  logic [CNT_W-1:0]   cnt      [NUM_OUT];
  logic [CNT_W-1:0]   cnt_next [NUM_OUT];
  logic [CNT_W-1:0]   snap     [NUM_OUT];
  logic [CNT_W-1:0]   best_val;
  logic [IDX_W-1:0]   best_idx;
  logic [IDX_W-1:0]   cur;
  logic               tie_r;
  logic [IW1-1:0]     idx_q;

  state_t state_q, state_d;
  logic   load_snap, do_cmp, publish, set_ovr;

  assign win_active = enable & (window_len != '0);

  spike_edge_detect u_edge (
    .clk       (clk),
    .reset     (reset),
    .delay_clk (delay_clk),
    .qual      (win_active),
    .step      (step)
  );

  // A window_len below step_cnt+1 never matches, so step_cnt wraps naturally.
  assign win_end = step && (step_cnt == (window_len - WIN_W'(1)));

  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      cnt_next[i] = CNT_W'(sat_inc(32'(cnt[i]), CNT_MAX, output_spikes[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !win_active) begin
      step_cnt <= '0;
      for (int i = 0; i < NUM_OUT; i++) cnt[i] <= '0;
    end else if (win_end) begin
      step_cnt <= '0;
      for (int i = 0; i < NUM_OUT; i++) cnt[i] <= '0;
    end else if (step) begin
      step_cnt <= step_cnt + WIN_W'(1);
      for (int i = 0; i < NUM_OUT; i++) cnt[i] <= cnt_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // CMP spends one cycle per neuron 1..NUM_OUT-1 and one more to publish,
  // giving result_valid NUM_OUT+1 cycles after the window-end step.
  always_comb begin
    state_d   = state_q;
    load_snap = 1'b0;
    do_cmp    = 1'b0;
    publish   = 1'b0;
    set_ovr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_end) begin
          load_snap = 1'b1;
          state_d   = ST_CMP;
        end
      end
      ST_CMP: begin
        if (idx_q == IW1'(NUM_OUT)) begin
          publish = 1'b1;
          state_d = ST_HOLD;
        end else begin
          do_cmp = 1'b1;
        end
        if (win_end) set_ovr = 1'b1;
      end
      ST_HOLD: begin
        if (result_ack) begin
          if (win_end) begin
            load_snap = 1'b1;
            state_d   = ST_CMP;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (win_end) begin
          set_ovr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cur          = idx_q[IDX_W-1:0];
  assign result_valid = (state_q == ST_HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT; i++) snap[i] <= '0;
      best_val     <= '0;
      best_idx     <= '0;
      tie_r        <= 1'b0;
      idx_q        <= '0;
      winner       <= '0;
      tie          <= 1'b0;
      spike_counts <= '0;
      overrun      <= 1'b0;
    end else begin
      if (load_snap) begin
        // Seed from cnt_next so the window's last step is counted.
        for (int i = 0; i < NUM_OUT; i++) snap[i] <= cnt_next[i];
        best_idx <= '0;
        best_val <= cnt_next[0];
        tie_r    <= (cnt_next[0] == '0);
        idx_q    <= IW1'(1);
      end else if (do_cmp) begin
        if (snap[cur] > best_val) begin
          best_idx <= cur;
          best_val <= snap[cur];
          tie_r    <= 1'b0;
        end else if (snap[cur] == best_val) begin
          tie_r <= 1'b1;
        end
        idx_q <= idx_q + IW1'(1);
      end
      if (publish) begin
        winner <= best_idx;
        tie    <= tie_r;
        for (int i = 0; i < NUM_OUT; i++) spike_counts[i*CNT_W +: CNT_W] <= snap[i];
      end
      if (set_ovr) overrun <= 1'b1;
    end
  end

`ifdef SPIKE_READOUT_HISTORY_EN
  always_ff @(posedge clk) begin
    if (reset || !enable) spike_history <= '0;
    else if (step)        spike_history <= {spike_history[3*NUM_OUT-1:0], output_spikes};
  end
`endif

endmodule

// File: tb/tb_spike_readout_accumulator.sv
module tb_spike_readout_accumulator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       delay_clk = 1'b0;
  logic [1:0] output_spikes = '0;
  logic [7:0] window_len = 8'd4;
  logic       result_ack = 1'b0;
  logic       result_valid;
  logic [0:0] winner;
  logic       tie;
  logic [7:0] spike_counts;
  logic       overrun;
`ifdef SPIKE_READOUT_HISTORY_EN
  logic [7:0] spike_history;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spike_readout_accumulator #(.NUM_OUT(2), .CNT_W(4), .WIN_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .delay_clk     (delay_clk),
    .output_spikes (output_spikes),
    .window_len    (window_len),
    .result_ack    (result_ack),
    .result_valid  (result_valid),
    .winner        (winner),
    .tie           (tie),
    .spike_counts  (spike_counts),
`ifdef SPIKE_READOUT_HISTORY_EN
    .spike_history (spike_history),
`endif
    .overrun       (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; delay_clk high for one cycle, then low for one.
  task automatic step_vec(input logic [1:0] v);
    output_spikes = v;
    delay_clk = 1'b1;
    @(negedge clk);
    delay_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
  endtask

  task automatic ack();
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wait_cyc(2);
    reset = 1'b0;
    enable = 1'b1;
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_tie", 32'(tie), 32'd0);
    chk("rst_counts", 32'(spike_counts), 32'h00);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // Window 1: 01,01,11,00 -> n0=3, n1=1
    step_vec(2'b01); step_vec(2'b01); step_vec(2'b11); step_vec(2'b00);
    chk("w1_latency_t2", 32'(result_valid), 32'd0);
    @(negedge clk);
    chk("w1_valid_t3", 32'(result_valid), 32'd1);
    chk("w1_counts", 32'(spike_counts), 32'h13);
    chk("w1_winner", 32'(winner), 32'd0);
    chk("w1_tie", 32'(tie), 32'd0);
    ack();
    chk("w1_ack_drop", 32'(result_valid), 32'd0);
    chk("w1_hold_counts", 32'(spike_counts), 32'h13);

    // Window 2: neuron 1 every step
    for (int i = 0; i < 4; i++) step_vec(2'b10);
    @(negedge clk);
    chk("w2_valid", 32'(result_valid), 32'd1);
    chk("w2_counts", 32'(spike_counts), 32'h40);
    chk("w2_winner", 32'(winner), 32'd1);
    chk("w2_tie", 32'(tie), 32'd0);
    ack();

    // Window 3: all zero -> tie
    for (int i = 0; i < 4; i++) step_vec(2'b00);
    @(negedge clk);
    chk("w3_valid", 32'(result_valid), 32'd1);
    chk("w3_counts", 32'(spike_counts), 32'h00);
    chk("w3_winner", 32'(winner), 32'd0);
    chk("w3_tie", 32'(tie), 32'd1);
    ack();

    // Saturation: 20 steps of neuron 0
    enable = 1'b0; @(negedge clk);
    window_len = 8'd20;
    enable = 1'b1;
    for (int i = 0; i < 19; i++) step_vec(2'b01);
    chk("sat_not_yet", 32'(result_valid), 32'd0);
    step_vec(2'b01);
    @(negedge clk);
    chk("sat_valid", 32'(result_valid), 32'd1);
    chk("sat_counts", 32'(spike_counts), 32'h0F);
    chk("sat_winner", 32'(winner), 32'd0);
    ack();
    enable = 1'b0; @(negedge clk);
    window_len = 8'd4;
    enable = 1'b1;

    // Overrun: first result left unconsumed
    step_vec(2'b11); step_vec(2'b00); step_vec(2'b00); step_vec(2'b00);
    @(negedge clk);
    chk("ovr_first_tie", 32'(tie), 32'd1);
    for (int i = 0; i < 4; i++) step_vec(2'b01);
    wait_cyc(2);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_counts_kept", 32'(spike_counts), 32'h11);
    chk("ovr_still_valid", 32'(result_valid), 32'd1);
    ack();
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Ack coincident with window end
    do_reset();
    chk("rst2_overrun", 32'(overrun), 32'd0);
    step_vec(2'b10); step_vec(2'b10); step_vec(2'b00); step_vec(2'b00);
    @(negedge clk);
    chk("coinc_first_winner", 32'(winner), 32'd1);
    step_vec(2'b01); step_vec(2'b01); step_vec(2'b01);
    result_ack = 1'b1;
    step_vec(2'b01);
    result_ack = 1'b0;
    @(negedge clk);
    chk("coinc_valid", 32'(result_valid), 32'd1);
    chk("coinc_counts", 32'(spike_counts), 32'h04);
    chk("coinc_winner", 32'(winner), 32'd0);
    chk("coinc_overrun", 32'(overrun), 32'd0);
    ack();

    // Enable drop aborts the window
    step_vec(2'b11); step_vec(2'b11);
    enable = 1'b0;
    wait_cyc(2);
    enable = 1'b1;
    step_vec(2'b01); step_vec(2'b01); step_vec(2'b01);
    wait_cyc(3);
    chk("abort_no_early_end", 32'(result_valid), 32'd0);
    step_vec(2'b01);
    @(negedge clk);
    chk("abort_valid", 32'(result_valid), 32'd1);
    chk("abort_counts", 32'(spike_counts), 32'h04);
    ack();

    // Reset while in CMP
    for (int i = 0; i < 4; i++) step_vec(2'b11);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    chk("midrst_counts", 32'(spike_counts), 32'h00);
    chk("midrst_winner", 32'(winner), 32'd0);
    chk("midrst_tie", 32'(tie), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    wait_cyc(3);
    chk("midrst_stays_idle", 32'(result_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spike_readout_accumulator.md
Name: spike_readout_accumulator

Overview:
- Consumes output_spikes from the SNN core, downstream of the spiking network top.
- Counts spikes per output neuron over a window of window_len SNN time steps. A step is one rising edge of delay_clk while enable is high.
- At window end, snapshots the counts and runs a sequential argmax to pick the winning neuron.
- Presents the result with a valid/ack handshake for the readout path (SPI or debug).

Parameters:
- NUM_OUT, 2, number of output neurons (width of output_spikes).
- CNT_W, 6, per-neuron spike counter width; counters saturate.
- WIN_W, 8, width of window_len.
- IDX_W, $clog2(NUM_OUT) (minimum 1), width of winner index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  SNN enable (input_spike_ready_sync & input_ready_sync).
- delay_clk  in  1  SNN step clock from clock_divider, generated in the clk domain.
- output_spikes  in  NUM_OUT  spike vector from the SNN output layer.
- window_len  in  WIN_W  steps per window; 0 = block idle.
- result_ack  in  1  consumer acknowledge.
- result_valid  out  1  result pending.
- winner  out  IDX_W  index of the max-count neuron.
- tie  out  1  max count shared by two or more neurons, or all counts zero.
- spike_counts  out  NUM_OUT*CNT_W  snapshot counts; neuron i at bits [i*CNT_W +: CNT_W].
- overrun  out  1  sticky: a window completed while the previous result was unconsumed.

Behaviour:
- Reset: all outputs 0, all counters 0, delay_clk_q 0, FSM in IDLE.
- Step detect: step = delay_clk & ~delay_clk_q & enable & (window_len != 0). delay_clk_q is delay_clk registered.
- Accumulation is independent of the result FSM. On each step:
  - cnt[i] += output_spikes[i], saturating at 2^CNT_W-1.
  - step_cnt increments.
- Window end: a step with step_cnt == window_len-1. That step's spikes are included in the window. Next cycle: cnt = 0, step_cnt = 0.
- enable low or window_len == 0: cnt and step_cnt cleared (window aborted). The result path is unaffected.
- window_len change mid-window: a new value below step_cnt+1 makes the window run until step_cnt wraps at 2^WIN_W. Software changes window_len only while enable is low.
- FSM states:
  - IDLE: waiting for a snapshot.
  - CMP: sequential argmax.
  - HOLD: result_valid = 1.
- IDLE -> CMP on window end:
  - snapshot regs <= final counts, including the last step.
  - best_idx = 0, best_val = snap[0], tie_r = (snap[0] == 0), idx = 1.
- CMP: one neuron per cycle. For idx = 1..NUM_OUT-1:
  - snap[idx] > best_val: replace best_idx and best_val, clear tie_r.
  - snap[idx] == best_val: set tie_r.
- After the last idx: -> HOLD, drive winner/tie/spike_counts, assert result_valid.
- NUM_OUT == 1: CMP takes zero compare cycles and goes directly to HOLD.
- Latency: window-end step in cycle t gives result_valid high from cycle t+NUM_OUT+1 (t+3 for NUM_OUT = 2).
- HOLD -> IDLE on result_ack. result_valid drops the next cycle. winner/tie/spike_counts hold their last values until the next snapshot.
- result_ack outside HOLD is ignored.
- Window end while in CMP or HOLD (without ack in the same cycle): the snapshot is dropped and overrun is set.
- Simultaneous result_ack in HOLD and window end: the ack is honoured and the new snapshot is accepted. The next state is CMP directly and overrun is not set.
- Clearing overrun: reset only.
- Reset mid-operation: immediate return to the reset state on the next edge.

Optional Feature:
- Macro: SPIKE_READOUT_HISTORY_EN.
- Defined:
  - Extra output port spike_history [4*NUM_OUT-1:0].
  - Shift register of the last 4 step vectors, newest in [NUM_OUT-1:0], shifted on each step.
  - Cleared on reset and when enable is low.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package snn_readout_pkg holds:
  - FSM state typedef (IDLE, CMP, HOLD).
  - Default constants NUM_OUT_DEF = 2, CNT_W_DEF = 6.
  - Saturating-increment function.
- One natural sub-module: spike_edge_detect (delay_clk rising-edge detector qualified by enable).
- Argmax stays inline in the FSM.

Test Plan (NUM_OUT=2, CNT_W=4, window_len=4):
- Spikes 01,01,11,00 over 4 steps -> result_valid at t+3: counts n0=3, n1=1, winner=0, tie=0. Ack -> result_valid drops next cycle.
- Spikes 10,10,10,10 -> n1=4, winner=1, tie=0. Then all-zero window -> winner=0, tie=1.
- window_len=20, output_spikes=01 on every step -> n0 saturates at 15, no wrap to 0; winner=0.
- No ack after the first result; second window completes -> overrun=1, spike_counts still hold the first window.
- Ack issued exactly on the window-end cycle -> new result appears with overrun=0.
- enable dropped after 2 steps, re-raised -> window restarts and needs 4 fresh steps. Assert reset mid-CMP -> all outputs 0 the next cycle.
